// File: rtl/seq_mult_unit.sv
// Multi-cycle radix-2 shift-add multiplier for MULT/MULTU.
// Produces the HI/LO product pair, with one WIDTH+1-bit add per cycle.
module seq_mult_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mcand_q;
    // After every shift the carry bit of the high accumulator is back to zero,
    // so only its lower WIDTH bits need storage.
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic             neg_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] acc_hi_d;
    logic [WIDTH-1:0] acc_lo_d;
    logic [PW-1:0]    prod_c;
    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic             neg_c;

    // Operand magnitudes, conditional add, shift and final sign correction.
    always_comb begin
        abs_a_c = a;
        abs_b_c = b;
        if (is_signed && a[WIDTH-1]) abs_a_c = ~a + WIDTH'(1);
        if (is_signed && b[WIDTH-1]) abs_b_c = ~b + WIDTH'(1);
        neg_c = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

        sum_c = {1'b0, acc_hi_q};
        if (acc_lo_q[0]) sum_c = {1'b0, acc_hi_q} + {1'b0, mcand_q};
        acc_hi_d = sum_c[WIDTH:1];
        acc_lo_d = {sum_c[0], acc_lo_q[WIDTH-1:1]};

        prod_c = {acc_hi_q, acc_lo_q};
        if (neg_q) prod_c = ~prod_c + PW'(1);
    end

    // Control FSM together with the accumulator datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        mcand_q  <= abs_a_c;
                        acc_hi_q <= '0;
                        acc_lo_q <= abs_b_c;
                        neg_q    <= neg_c;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= prod_c[PW-1:WIDTH];
                    lo_q    <= prod_c[WIDTH-1:0];
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit with hand-computed products.
module tb_seq_mult_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    seq_mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation from IDLE; scrambles inputs while busy and pokes start at cycle 10.
    task automatic do_mult(input string tag, input logic sgn, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
        int c;
        int dc;
        int bc;
        @(negedge clk);
        start = 1'b1; is_signed = sgn; a = av; b = bv;
        @(posedge clk);
        c = 0; dc = 0; bc = 0;
        while (dc == 0 && c < 100) begin
            @(negedge clk);
            c++;
            start     = (c == 10);
            a         = (c == 10) ? 32'd1 : $urandom;
            b         = (c == 10) ? 32'd1 : $urandom;
            is_signed = 1'($urandom_range(1, 0));
            if (busy) bc++;
            if (done) dc = c;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(dc), 64'd34);
        chk({tag, "_busy_cycles"}, 64'(bc), 64'd33);
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int c;
        int dc;
        int ndone;

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_mult("u_ffff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_mult("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_mult("s_5xm3", 1'b1, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_mult("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        do_mult("u_min2", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        do_mult("s_0xm1", 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        do_mult("s_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
        do_mult("s_m1x1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_mult("u_m1x1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF);
        do_mult("u_2p32", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0);

        // Result holds across idle cycles.
        repeat (5) @(negedge clk);
        chk("hold_hi", 64'(hi), 64'd1);
        chk("hold_lo", 64'(lo), 64'd0);

        // Back-to-back: 7*6, then restart in the DONE cycle with 3*4.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd7; b = 32'd6;
        @(posedge clk);
        c = 0; dc = 0;
        while (dc == 0 && c < 100) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (done) dc = c;
        end
        chk("b2b_first_latency", 64'(dc), 64'd34);
        chk("b2b_first_hi", 64'(hi), 64'd0);
        chk("b2b_first_lo", 64'(lo), 64'd42);
        start = 1'b1; a = 32'd3; b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'hFFFF_FFFF;
        chk("b2b_busy_next", 64'(busy), 64'd1);
        chk("b2b_lo_not_cleared", 64'(lo), 64'd42);
        c = 1; dc = 0;
        if (done) dc = c;
        while (dc == 0 && c < 100) begin
            @(negedge clk);
            c++;
            if (done) dc = c;
        end
        chk("b2b_second_latency", 64'(dc), 64'd34);
        chk("b2b_second_hi", 64'(hi), 64'd0);
        chk("b2b_second_lo", 64'(lo), 64'd12);
        @(negedge clk);

        // Asynchronous reset mid-run.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst_no_done", 64'(ndone), 64'd0);
        do_mult("post_rst", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
